radix4_seq_mult: RTL and testbench

//  Parametrised sequential radix-4 (modified Booth) multiplier.
//  - Retires one 2-bit Booth digit of B per clock, with signed or unsigned operands selected per operation.
//  - Sits between operand registers and the datapath accumulator.
//  - Replaces the fixed 8x2 combinational partial-product slice with a WIDTHxWIDTH engine.
//  - Valid/ready handshakes on both input and output.

---
 rtl/radix4_seq_mult.sv | 146 ++++++++++++++
 tb/tb_radix4_seq_mult.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_seq_mult.sv
// radix4_seq_mult: sequential radix-4 (modified Booth) multiplier.
// One Booth digit of B is retired per clock; WIDTH/2+1 digits per operation.
// Operands are signed or unsigned per operation (signed_i, sampled on accept).
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   valid_i      operands valid
//   ready_o      block can accept operands this cycle
//   A_i, B_i     multiplicand / multiplier, WIDTH bits
//   signed_i     1: two's complement operands, 0: unsigned
//   valid_o      product_o holds a result not yet consumed
//   out_ready_i  consumer accepts the result
//   product_o    2*WIDTH-bit product, held until the next completion
//   busy_o       digits are being processed (CALC)
module radix4_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [WIDTH-1:0]       A_i,
    input  logic [WIDTH-1:0]       B_i,
    input  logic                   signed_i,
    output logic                   valid_o,
    input  logic                   out_ready_i,
    output logic [2*WIDTH-1:0]     product_o,
    output logic                   busy_o
);

    localparam int unsigned EW = WIDTH + 2;        // extended operand width
    localparam int unsigned AW = 2 * WIDTH + 2;    // accumulator width
    localparam int unsigned N  = WIDTH / 2 + 1;    // Booth digits per operation
    localparam int unsigned CW = $clog2(N + 1);    // digit counter width

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("radix4_seq_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            accept;
    logic            last_digit;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [AW-1:0]   a_sh;       // Ae sign-extended to AW bits, pre-shifted by 2i
    logic [AW-1:0]   a_dbl;
    logic [EW:0]     b_sh;       // {Be, 1'b0}; bits [2:0] hold the current triplet
    logic [AW-1:0]   pp;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_sum;
    logic [CW-1:0]   cnt;

    // Handshake decode (combinational by definition of the interface)
    always_comb begin
        ready_o    = (state == IDLE) || ((state == DONE) && out_ready_i);
        accept     = valid_i && ready_o;
        last_digit = (state == CALC) && (cnt == CW'(N - 1));
    end

    // Operand extension by sign or zero
    always_comb begin
        a_ext = signed_i ? {{2{A_i[WIDTH-1]}}, A_i} : {2'b00, A_i};
        b_ext = signed_i ? {{2{B_i[WIDTH-1]}}, B_i} : {2'b00, B_i};
    end

    // Booth digit selection and accumulate
    always_comb begin
        a_dbl = {a_sh[AW-2:0], 1'b0};
        pp    = '0;
        unique case (b_sh[2:0])
            3'b001, 3'b010: pp = a_sh;
            3'b011:         pp = a_dbl;
            3'b100:         pp = -a_dbl;
            3'b101, 3'b110: pp = -a_sh;
            default:        pp = '0;
        endcase
        acc_sum = acc + pp;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: if (last_digit) state_next = DONE;
            DONE: begin
                if (out_ready_i) begin
                    state_next = valid_i ? CALC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_o <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            valid_o <= (state_next == DONE);
            busy_o  <= (state_next == CALC);
            if (accept) begin
                a_sh <= {{WIDTH{a_ext[EW-1]}}, a_ext};
                b_sh <= {b_ext, 1'b0};
                acc  <= '0;
                cnt  <= '0;
            end else if (state == CALC) begin
                acc  <= acc_sum;
                a_sh <= {a_sh[AW-3:0], 2'b00};
                b_sh <= {2'b00, b_sh[EW:2]};
                cnt  <= cnt + CW'(1);
                // Top two accumulator bits are only needed during the sum
                if (last_digit) begin
                    product_o <= acc_sum[2*WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_radix4_seq_mult.sv
// tb_radix4_seq_mult: directed + random bench for radix4_seq_mult at WIDTH=8
// and WIDTH=16. Expected products come from a plain extended-multiply model,
// queued at drive time and popped when the result is consumed.
module tb_radix4_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        valid8 = 1'b0, signed8 = 1'b0, oready8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, vout8, busy8;
    logic [15:0] prod8;

    // WIDTH=16 instance
    logic        valid16 = 1'b0, signed16 = 1'b0, oready16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ready16, vout16, busy16;
    logic [31:0] prod16;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q8[$];
    logic [31:0] q16[$];

    radix4_seq_mult #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid8), .ready_o(ready8),
        .A_i(a8), .B_i(b8), .signed_i(signed8), .valid_o(vout8),
        .out_ready_i(oready8), .product_o(prod8), .busy_o(busy8)
    );

    radix4_seq_mult #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid16), .ready_o(ready16),
        .A_i(a16), .B_i(b16), .signed_i(signed16), .valid_o(vout16),
        .out_ready_i(oready16), .product_o(prod16), .busy_o(busy16)
    );

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [31:0] ea, eb;
        ea = s ? {{16{a[15]}}, a} : {16'h0000, a};
        eb = s ? {{16{b[15]}}, b} : {16'h0000, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Count edges from accept until valid_o, checking latency and busy_o span
    task automatic wait_done8(input string tag);
        int lat, nb;
        lat = 0;
        nb  = 0;
        while (!vout8 && lat < 50) begin
            if (busy8) nb++;
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd5);
        check({tag, " busy cycles"}, 64'(nb), 64'd5);
    endtask

    task automatic wait_done16(input string tag);
        int lat, nb;
        lat = 0;
        nb  = 0;
        while (!vout16 && lat < 80) begin
            if (busy16) nb++;
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd9);
        check({tag, " busy cycles"}, 64'(nb), 64'd9);
    endtask

    // Issue one operation; operands are scrambled right after the accept edge
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        int c;
        c = 0;
        while (!ready8 && c < 50) begin step(); c++; end
        check({tag, " ready"}, 64'(ready8), 64'd1);
        a8 = a; b8 = b; signed8 = s; valid8 = 1'b1;
        q8.push_back(model8(a, b, s));
        step();
        valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); signed8 = ~s;
        wait_done8(tag);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
        int c;
        c = 0;
        while (!ready16 && c < 50) begin step(); c++; end
        check({tag, " ready"}, 64'(ready16), 64'd1);
        a16 = a; b16 = b; signed16 = s; valid16 = 1'b1;
        q16.push_back(model16(a, b, s));
        step();
        valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); signed16 = ~s;
        wait_done16(tag);
    endtask

    // Hold off the consumer for a few cycles, then compare and consume
    task automatic take8(input string tag, input int hold);
        logic [15:0] exp;
        repeat (hold) step();
        check({tag, " valid"}, 64'(vout8), 64'd1);
        if (q8.size() == 0) check({tag, " queue"}, 64'(q8.size()), 64'd1);
        exp = (q8.size() != 0) ? q8.pop_front() : 16'h0;
        check({tag, " product"}, 64'(prod8), 64'(exp));
        oready8 = 1'b1;
        step();
        oready8 = 1'b0;
    endtask

    task automatic take16(input string tag, input int hold);
        logic [31:0] exp;
        repeat (hold) step();
        check({tag, " valid"}, 64'(vout16), 64'd1);
        if (q16.size() == 0) check({tag, " queue"}, 64'(q16.size()), 64'd1);
        exp = (q16.size() != 0) ? q16.pop_front() : 32'h0;
        check({tag, " product"}, 64'(prod16), 64'(exp));
        oready16 = 1'b1;
        step();
        oready16 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        int          k;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst valid_o", 64'(vout8), 64'd0);
        check("rst busy_o", 64'(busy8), 64'd0);
        check("rst product_o", 64'(prod8), 64'd0);
        rst = 1'b0;
        step();
        check("rst ready_o", 64'(ready8), 64'd1);
        check("rst ready_o w16", 64'(ready16), 64'd1);

        // Unsigned
        op8(8'd255, 8'd255, 1'b0, "u 255*255");
        take8("u 255*255", 0);
        op8(8'd200, 8'd3, 1'b0, "u 200*3");
        take8("u 200*3", 0);
        check("u 200*3 literal", 64'(prod8), 64'h0258);

        // Signed
        op8(8'h80, 8'h80, 1'b1, "s -128*-128");
        take8("s -128*-128", 0);
        check("s -128*-128 literal", 64'(prod8), 64'h4000);
        op8(8'h80, 8'h7F, 1'b1, "s -128*127");
        take8("s -128*127", 0);
        op8(8'hFF, 8'h7F, 1'b1, "s -1*127");
        take8("s -1*127", 0);
        op8(8'h00, 8'h80, 1'b1, "s 0*-128");
        take8("s 0*-128", 0);

        // Backpressure: result held, new operands refused for 10 cycles
        op8(8'd37, 8'hC9, 1'b1, "bp");
        held = q8[0];
        for (int i = 0; i < 10; i++) begin
            valid8 = 1'b1; a8 = 8'd9; b8 = 8'd9; signed8 = 1'b0;
            step();
            check("bp valid_o", 64'(vout8), 64'd1);
            check("bp product_o", 64'(prod8), 64'(held));
            check("bp ready_o", 64'(ready8), 64'd0);
        end
        valid8 = 1'b0;
        take8("bp", 0);
        check("bp idle ready_o", 64'(ready8), 64'd1);
        check("bp idle busy_o", 64'(busy8), 64'd0);
        check("bp idle valid_o", 64'(vout8), 64'd0);

        // Back-to-back with mode switch signed -> unsigned
        op8(8'hFD, 8'd7, 1'b1, "b2b first");
        check("b2b first valid", 64'(vout8), 64'd1);
        check("b2b first product", 64'(prod8), 64'(q8.pop_front()));
        oready8 = 1'b1; valid8 = 1'b1; a8 = 8'd250; b8 = 8'd4; signed8 = 1'b0;
        q8.push_back(model8(8'd250, 8'd4, 1'b0));
        step();
        oready8 = 1'b0; valid8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; signed8 = 1'b1;
        check("b2b valid drop", 64'(vout8), 64'd0);
        check("b2b busy", 64'(busy8), 64'd1);
        wait_done8("b2b second");
        take8("b2b second", 0);

        // Asynchronous reset two cycles into CALC discards the operation
        a8 = 8'd100; b8 = 8'd100; signed8 = 1'b0; valid8 = 1'b1;
        step();
        valid8 = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("mid rst valid_o", 64'(vout8), 64'd0);
        check("mid rst product_o", 64'(prod8), 64'd0);
        check("mid rst busy_o", 64'(busy8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        op8(8'd3, 8'd5, 1'b0, "post rst 3*5");
        take8("post rst 3*5", 0);
        check("post rst literal", 64'(prod8), 64'h000F);

        // Random WIDTH=8, including edge operands and consumer stalls
        for (k = 0; k < 800; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'hFF;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h7F;
            op8(ra, rb, 1'($urandom), "rand8");
            take8("rand8", int'($urandom_range(0, 2)));
        end

        // WIDTH=16 directed
        op16(16'hFFFF, 16'hFFFF, 1'b0, "w16 u max");
        take16("w16 u max", 0);
        check("w16 u max literal", 64'(prod16), 64'hFFFE0001);
        op16(16'h8000, 16'h8000, 1'b1, "w16 s min");
        take16("w16 s min", 0);
        check("w16 s min literal", 64'(prod16), 64'h40000000);

        // Random WIDTH=16 in both modes
        for (k = 0; k < 1500; k++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            if ($urandom_range(0, 5) == 0) wa = 16'h8000;
            if ($urandom_range(0, 5) == 0) wb = 16'hFFFF;
            op16(wa, wb, 1'($urandom), "rand16");
            take16("rand16", int'($urandom_range(0, 1)));
        end

        check("queue8 drained", 64'(q8.size()), 64'd0);
        check("queue16 drained", 64'(q16.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
